// File: rtl/motion_reconstruction.sv
// Motion-compensated block reconstruction: recon = ref + residual, one lane per cycle.
// Optional saturation with clip counting is enabled by defining MC_RECON_CLIP_EN.
module motion_reconstruction #(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int RES_WIDTH   = PIXEL_WIDTH + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PIXEL_WIDTH*MB_SIZE-1:0]   ref_frame,
  input  logic [RES_WIDTH*MB_SIZE-1:0]     residual,
  input  logic                             src_valid,
  output logic                             src_ready,
  output logic                             dst_valid,
  input  logic                             dst_ready,
  output logic [PIXEL_WIDTH*MB_SIZE-1:0]   recon,
  output logic [$clog2(MB_SIZE+1)-1:0]     clip_count
);

  // Sums are formed at PIXEL_WIDTH+2 bits; RES_WIDTH must stay below that.
  localparam int SUM_W  = PIXEL_WIDTH + 2;
  localparam int LANE_W = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
  localparam int CNT_W  = $clog2(MB_SIZE + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MB_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECON = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t                           state_r;
  state_t                           state_n_s;
  logic [LANE_W-1:0]                lane_r;
  logic [PIXEL_WIDTH*MB_SIZE-1:0]   ref_r;
  logic [RES_WIDTH*MB_SIZE-1:0]     res_r;
  logic [PIXEL_WIDTH*MB_SIZE-1:0]   recon_r;
  logic [CNT_W-1:0]                 clip_r;
  logic                             dst_valid_r;
  logic                             src_ready_r;
  logic [PIXEL_WIDTH-1:0]           ref_lane_s;
  logic [RES_WIDTH-1:0]             res_lane_s;
  logic [PIXEL_WIDTH-1:0]           pix_s;
  logic                             clip_hit_s;

  function automatic logic [SUM_W-1:0] lane_sum(input logic [PIXEL_WIDTH-1:0] pix,
                                               input logic [RES_WIDTH-1:0]   res);
    logic [SUM_W-1:0] res_ext;
    res_ext = {{(SUM_W-RES_WIDTH){res[RES_WIDTH-1]}}, res};
    return {2'b00, pix} + res_ext;
  endfunction

`ifdef MC_RECON_CLIP_EN
  logic [SUM_W-1:0] sum_s;

  // Negative sums have the top bit set; bit PIXEL_WIDTH flags an overflow past full scale.
  function automatic logic lane_clipped(input logic [SUM_W-1:0] sum);
    return sum[SUM_W-1] | sum[SUM_W-2];
  endfunction

  function automatic logic [PIXEL_WIDTH-1:0] lane_saturate(input logic [SUM_W-1:0] sum);
    logic [PIXEL_WIDTH-1:0] pix;
    if (sum[SUM_W-1]) begin
      pix = {PIXEL_WIDTH{1'b0}};
    end else if (sum[SUM_W-2]) begin
      pix = {PIXEL_WIDTH{1'b1}};
    end else begin
      pix = sum[PIXEL_WIDTH-1:0];
    end
    return pix;
  endfunction

  // Saturating lane result and clip detection.
  always_comb begin
    sum_s      = lane_sum(ref_lane_s, res_lane_s);
    pix_s      = lane_saturate(sum_s);
    clip_hit_s = lane_clipped(sum_s);
  end
`else
  function automatic logic [PIXEL_WIDTH-1:0] lane_wrap(input logic [PIXEL_WIDTH-1:0] pix,
                                                      input logic [RES_WIDTH-1:0]   res);
    logic [SUM_W-1:0] sum;
    sum = lane_sum(pix, res);
    return sum[PIXEL_WIDTH-1:0];
  endfunction

  // Wrapping lane result; nothing ever counts as clipped.
  always_comb begin
    pix_s      = lane_wrap(ref_lane_s, res_lane_s);
    clip_hit_s = 1'b0;
  end
`endif

  // Select the operands of the lane currently being reconstructed.
  always_comb begin
    ref_lane_s = ref_r[lane_r*PIXEL_WIDTH +: PIXEL_WIDTH];
    res_lane_s = res_r[lane_r*RES_WIDTH +: RES_WIDTH];
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (src_valid) begin
          state_n_s = RECON;
        end else begin
          state_n_s = IDLE;
        end
      end
      RECON: begin
        if (lane_r == LAST_LANE) begin
          state_n_s = OUT;
        end else begin
          state_n_s = RECON;
        end
      end
      OUT: begin
        if (dst_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = OUT;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Capture, per-lane reconstruction and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_r      <= {LANE_W{1'b0}};
      ref_r       <= {(PIXEL_WIDTH*MB_SIZE){1'b0}};
      res_r       <= {(RES_WIDTH*MB_SIZE){1'b0}};
      recon_r     <= {(PIXEL_WIDTH*MB_SIZE){1'b0}};
      clip_r      <= {CNT_W{1'b0}};
      dst_valid_r <= 1'b0;
      src_ready_r <= 1'b1;
    end else begin
      dst_valid_r <= (state_n_s == OUT);
      src_ready_r <= (state_n_s == IDLE);
      case (state_r)
        IDLE: begin
          if (src_valid) begin
            ref_r  <= ref_frame;
            res_r  <= residual;
            lane_r <= {LANE_W{1'b0}};
            clip_r <= {CNT_W{1'b0}};
          end
        end
        RECON: begin
          recon_r[lane_r*PIXEL_WIDTH +: PIXEL_WIDTH] <= pix_s;
          if (clip_hit_s) begin
            clip_r <= clip_r + CNT_W'(1);
          end
          // Index parks on the last lane rather than wrapping.
          if (lane_r != LAST_LANE) begin
            lane_r <= lane_r + LANE_W'(1);
          end
        end
        OUT: begin
          lane_r <= lane_r;
        end
        default: begin
          lane_r <= {LANE_W{1'b0}};
        end
      endcase
    end
  end

  assign src_ready  = src_ready_r;
  assign dst_valid  = dst_valid_r;
  assign recon      = recon_r;
  assign clip_count = clip_r;

endmodule

// File: tb/tb_motion_reconstruction.sv
// Directed bench for motion_reconstruction (default parameters); expectations follow
// MC_RECON_CLIP_EN when the bench is compiled with that macro.
module tb_motion_reconstruction;

  logic        clk;
  logic        reset;
  logic [31:0] ref_frame;
  logic [35:0] residual;
  logic        src_valid;
  logic        src_ready;
  logic        dst_valid;
  logic        dst_ready;
  logic [31:0] recon;
  logic [2:0]  clip_count;

  int errors;
  int checks;

  // Vectors are written MSB lane first: {lane3, lane2, lane1, lane0}.
  localparam logic [31:0] BASIC_REF = {8'd55, 8'd23, 8'd1, 8'd2};
  localparam logic [35:0] BASIC_RES = {9'd5, 9'd7, 9'd4, 9'd8};
  localparam logic [31:0] BASIC_EXP = {8'd60, 8'd30, 8'd5, 8'd10};

  // lane0 250+10, lane1 3-5, lane2 100+0, lane3 17-17
  localparam logic [31:0] CLIP_REF = {8'd17, 8'd100, 8'd3, 8'd250};
  localparam logic [35:0] CLIP_RES = {9'h1EF, 9'd0, 9'h1FB, 9'd10};
  // lane0 128-256, lane1 255+0, lane2 0-1, lane3 255+1
  localparam logic [31:0] EDGE_REF = {8'd255, 8'd0, 8'd255, 8'd128};
  localparam logic [35:0] EDGE_RES = {9'd1, 9'h1FF, 9'd0, 9'h100};
`ifdef MC_RECON_CLIP_EN
  localparam logic [31:0] CLIP_EXP  = {8'd0, 8'd100, 8'd0, 8'd255};
  localparam logic [2:0]  CLIP_CNT  = 3'd2;
  localparam logic [7:0]  CLIP_L0   = 8'd255;
  localparam logic [31:0] EDGE_EXP  = {8'd255, 8'd0, 8'd255, 8'd0};
  localparam logic [2:0]  EDGE_CNT  = 3'd3;
`else
  localparam logic [31:0] CLIP_EXP  = {8'd0, 8'd100, 8'd254, 8'd4};
  localparam logic [2:0]  CLIP_CNT  = 3'd0;
  localparam logic [7:0]  CLIP_L0   = 8'd4;
  localparam logic [31:0] EDGE_EXP  = {8'd0, 8'd255, 8'd255, 8'd128};
  localparam logic [2:0]  EDGE_CNT  = 3'd0;
`endif

  motion_reconstruction dut (
    .clk        (clk),
    .reset      (reset),
    .ref_frame  (ref_frame),
    .residual   (residual),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .recon      (recon),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one block from IDLE, waits for dst_valid, records outputs, then transfers it.
  // lat counts rising edges after the capture edge until dst_valid is seen (0 = timeout).
  task automatic send_block(input logic [31:0] rf, input logic [35:0] rs,
                            output int lat, output logic [31:0] rc, output logic [2:0] cc);
    ref_frame = rf;
    residual  = rs;
    src_valid = 1'b1;
    dst_ready = 1'b0;
    tick;
    src_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (dst_valid) begin
        lat = n;
        break;
      end
    end
    rc = recon;
    cc = clip_count;
    dst_ready = 1'b1;
    tick;
    dst_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    ref_frame = 32'd0; residual = 36'd0;
    #2;
    checks++; if (recon !== 32'd0) begin errors++; $display("FAIL reset_recon: got %h expected %h", recon, 32'd0); end
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset_dst_valid: got %b expected 0", dst_valid); end
    checks++; if (clip_count !== 3'd0) begin errors++; $display("FAIL reset_clip: got %0d expected 0", clip_count); end
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    tick;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready: got %b expected 1", src_ready); end
  endtask

  task automatic test_basic;
    int lat; logic [31:0] rc; logic [2:0] cc;
    send_block(BASIC_REF, BASIC_RES, lat, rc, cc);
    // Four edges after capture: dst_valid is up in the fifth cycle counting the capture cycle.
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (rc !== BASIC_EXP) begin errors++; $display("FAIL basic_recon: got %h expected %h", rc, BASIC_EXP); end
    checks++; if (cc !== 3'd0) begin errors++; $display("FAIL basic_clip: got %0d expected 0", cc); end
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL basic_after_dv: got %b expected 0", dst_valid); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL basic_after_sr: got %b expected 1", src_ready); end
  endtask

  // Starts from recon = BASIC_EXP; unprocessed lanes must keep those values.
  task automatic test_clip_and_hold;
    int lat; logic [31:0] rc; logic [2:0] cc; bit seen;
    ref_frame = CLIP_REF; residual = CLIP_RES; src_valid = 1'b1;
    tick;
    src_valid = 1'b0;
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL hold_src_ready: got %b expected 0", src_ready); end
    checks++; if (recon !== BASIC_EXP) begin errors++; $display("FAIL hold_capture: got %h expected %h", recon, BASIC_EXP); end
    tick;
    checks++; if (recon !== {BASIC_EXP[31:8], CLIP_L0}) begin errors++; $display("FAIL hold_lane0: got %h expected %h", recon, {BASIC_EXP[31:8], CLIP_L0}); end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (dst_valid) begin seen = 1'b1; break; end
      tick;
    end
    checks++; if (!seen) begin errors++; $display("FAIL clip_timeout: got no dst_valid expected dst_valid"); end
    checks++; if (recon !== CLIP_EXP) begin errors++; $display("FAIL clip_recon: got %h expected %h", recon, CLIP_EXP); end
    checks++; if (clip_count !== CLIP_CNT) begin errors++; $display("FAIL clip_count: got %0d expected %0d", clip_count, CLIP_CNT); end
    dst_ready = 1'b1; tick; dst_ready = 1'b0;
    send_block(EDGE_REF, EDGE_RES, lat, rc, cc);
    checks++; if (rc !== EDGE_EXP) begin errors++; $display("FAIL edge_recon: got %h expected %h", rc, EDGE_EXP); end
    checks++; if (cc !== EDGE_CNT) begin errors++; $display("FAIL edge_clip: got %0d expected %0d", cc, EDGE_CNT); end
  endtask

  task automatic test_backpressure;
    bit seen;
    ref_frame = BASIC_REF; residual = BASIC_RES; src_valid = 1'b1; dst_ready = 1'b0;
    tick;
    src_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (dst_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout: got no dst_valid expected dst_valid"); end
    for (int i = 0; i < 7; i++) begin
      src_valid = ~src_valid;
      ref_frame = $urandom;
      residual  = {4'd0, $urandom};
      tick;
      checks++; if (dst_valid !== 1'b1) begin errors++; $display("FAIL bp_dv_%0d: got %b expected 1", i, dst_valid); end
      checks++; if (recon !== BASIC_EXP) begin errors++; $display("FAIL bp_recon_%0d: got %h expected %h", i, recon, BASIC_EXP); end
      checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL bp_sr_%0d: got %b expected 0", i, src_ready); end
    end
    src_valid = 1'b0; dst_ready = 1'b1;
    tick;
    dst_ready = 1'b0;
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL bp_release_dv: got %b expected 0", dst_valid); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL bp_release_sr: got %b expected 1", src_ready); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rc; logic [2:0] cc; bit pulse;
    ref_frame = CLIP_REF; residual = CLIP_RES; src_valid = 1'b1; dst_ready = 1'b1;
    tick;
    src_valid = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
    checks++; if (recon !== 32'd0) begin errors++; $display("FAIL mid_recon: got %h expected %h", recon, 32'd0); end
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL mid_dv: got %b expected 0", dst_valid); end
    checks++; if (clip_count !== 3'd0) begin errors++; $display("FAIL mid_clip: got %0d expected 0", clip_count); end
    @(posedge clk);
    #3 reset = 1'b1;
    tick;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL mid_src_ready: got %b expected 1", src_ready); end
    pulse = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (dst_valid) pulse = 1'b1;
      tick;
    end
    checks++; if (pulse) begin errors++; $display("FAIL mid_no_pulse: got dst_valid pulse expected none"); end
    dst_ready = 1'b0;
    send_block(BASIC_REF, BASIC_RES, lat, rc, cc);
    checks++; if (rc !== BASIC_EXP) begin errors++; $display("FAIL mid_next_recon: got %h expected %h", rc, BASIC_EXP); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_next_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] bref [3];
    logic [35:0] bres [3];
    logic [31:0] bexp [3];
    int times [3];
    int nin, nout;
    bit prev_dv;
    bref[0] = BASIC_REF;                       bres[0] = BASIC_RES;
    bexp[0] = BASIC_EXP;
    bref[1] = {8'd10, 8'd20, 8'd30, 8'd40};    bres[1] = {9'd1, 9'h1FE, 9'd3, 9'h1FC};
    bexp[1] = {8'd11, 8'd18, 8'd33, 8'd36};
    bref[2] = {8'd200, 8'd100, 8'd50, 8'd0};   bres[2] = {9'd50, 9'h19C, 9'h1CE, 9'd7};
    bexp[2] = {8'd250, 8'd0, 8'd0, 8'd7};
    nin = 0; nout = 0; prev_dv = 1'b0;
    src_valid = 1'b1; dst_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
      if (src_ready && nin < 3) begin
        ref_frame = bref[nin];
        residual  = bres[nin];
        nin++;
      end
      tick;
      if (dst_valid) begin
        checks++; if (prev_dv) begin errors++; $display("FAIL b2b_pulse_%0d: got 2+ cycle pulse expected 1", nout); end
        checks++; if (recon !== bexp[nout]) begin errors++; $display("FAIL b2b_recon_%0d: got %h expected %h", nout, recon, bexp[nout]); end
        times[nout] = cyc;
        nout++;
      end
      prev_dv = dst_valid;
    end
    src_valid = 1'b0;
    tick;
    dst_ready = 1'b0;
    checks++; if (nout !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", nout); end
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL b2b_last_pulse: got %b expected 0", dst_valid); end
    if (nout == 3) begin
      checks++; if (times[1] - times[0] != 6) begin errors++; $display("FAIL b2b_gap_01: got %0d expected 6", times[1] - times[0]); end
      checks++; if (times[2] - times[1] != 6) begin errors++; $display("FAIL b2b_gap_12: got %0d expected 6", times[2] - times[1]); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_basic;
    test_clip_and_hold;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
